// File: rtl/delay_mod_ctrl.sv
// delay_mod_ctrl: sequences a delay_core instance with a per-sample enable,
// a slewed base delay, a clamped triangle-LFO modulation value and a
// tick-aligned bypass. All outputs come straight from flops.
module delay_mod_ctrl #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned RATE_W        = 12,
  parameter int unsigned DEFAULT_DELAY = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic                run,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ADDR_W-1:0]   cfg_delay,
  input  logic [ADDR_W-1:0]   cfg_depth,
  input  logic [RATE_W-1:0]   cfg_rate,
  input  logic                bypass_req,
  output logic                core_en,
  output logic                core_bypass,
  output logic [ADDR_W-1:0]   core_base_delay,
  output logic signed [15:0]  core_mod_val,
  output logic                busy
);

  localparam int unsigned LW = ADDR_W + 1;  // LFO width (signed)
  localparam int unsigned SW = ADDR_W + 2;  // clamp arithmetic width (signed)

  localparam logic signed [LW-1:0] LFO_ZERO = '0;
  localparam logic signed [LW-1:0] LFO_ONE  = LW'(1);
  localparam logic signed [SW-1:0] MOD_MIN  = SW'(1);
  localparam logic signed [SW-1:0] MOD_MAX  = $signed({2'b00, {ADDR_W{1'b1}}});

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SLEW} state_t;

  state_t                state, state_nx;
  logic [ADDR_W-1:0]     cur, cur_nx;
  logic [ADDR_W-1:0]     target, target_nx;
  logic [ADDR_W-1:0]     depth, depth_nx;
  logic [RATE_W-1:0]     rate, rate_nx;
  logic [RATE_W-1:0]     rate_cnt, rate_cnt_nx;
  logic signed [LW-1:0]  lfo, lfo_nx;
  logic signed [LW-1:0]  depth_s;
  logic                  dir, dir_nx;      // 0 = up, 1 = down
  logic                  step_down;
  logic                  accept;
  logic                  tick_act;
  logic signed [SW-1:0]  cur_s, lfo_ext, mod_sum, mod_nx;

  assign core_base_delay = cur;

  // Next-state, slew, LFO and clamp computation
  always_comb begin
    state_nx    = state;
    cur_nx      = cur;
    target_nx   = target;
    depth_nx    = depth;
    rate_nx     = rate;
    rate_cnt_nx = rate_cnt;
    lfo_nx      = lfo;
    dir_nx      = dir;
    step_down   = dir;
    tick_act    = 1'b0;
    depth_s     = $signed({1'b0, depth});
    accept      = cfg_valid && cfg_ready;

    if (accept) begin
      target_nx = cfg_delay;
      depth_nx  = cfg_depth;
      rate_nx   = cfg_rate;
    end

    if (!run || state == ST_IDLE) begin
      // Idle (or leaving for idle): delay snaps, LFO restarts from zero
      state_nx    = run ? ST_RUN : ST_IDLE;
      cur_nx      = target_nx;
      lfo_nx      = LFO_ZERO;
      dir_nx      = 1'b0;
      rate_cnt_nx = '0;
    end else begin
      if (state == ST_RUN && accept && cfg_delay != cur)
        state_nx = ST_SLEW;
      if (sample_tick) begin
        tick_act = 1'b1;
        if (state == ST_SLEW) begin
          cur_nx = (cur < target) ? cur + ADDR_W'(1) : cur - ADDR_W'(1);
          if (cur_nx == target)
            state_nx = ST_RUN;
        end
        if (rate_cnt == rate) begin
          rate_cnt_nx = '0;
          if (depth == '0) begin
            if (lfo > LFO_ZERO)      lfo_nx = lfo - LFO_ONE;
            else if (lfo < LFO_ZERO) lfo_nx = lfo + LFO_ONE;
          end else begin
            // Out-of-range or at-peak values force the direction back inward
            if (lfo >= depth_s)       step_down = 1'b1;
            else if (lfo <= -depth_s) step_down = 1'b0;
            lfo_nx = step_down ? lfo - LFO_ONE : lfo + LFO_ONE;
            dir_nx = step_down;
            if (lfo_nx >= depth_s)       dir_nx = 1'b1;
            else if (lfo_nx <= -depth_s) dir_nx = 1'b0;
          end
        end else begin
          rate_cnt_nx = rate_cnt + RATE_W'(1);
        end
      end
    end

    // Saturate so the effective delay cur + mod stays in [1, 2^ADDR_W-1]
    cur_s   = $signed({2'b00, cur_nx});
    lfo_ext = {lfo_nx[LW-1], lfo_nx};
    mod_sum = cur_s + lfo_ext;
    if (mod_sum < MOD_MIN)      mod_nx = MOD_MIN - cur_s;
    else if (mod_sum > MOD_MAX) mod_nx = MOD_MAX - cur_s;
    else                        mod_nx = lfo_ext;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cur          <= ADDR_W'(DEFAULT_DELAY);
      target       <= ADDR_W'(DEFAULT_DELAY);
      depth        <= '0;
      rate         <= '0;
      rate_cnt     <= '0;
      lfo          <= LFO_ZERO;
      dir          <= 1'b0;
      core_en      <= 1'b0;
      core_bypass  <= 1'b0;
      core_mod_val <= '0;
      cfg_ready    <= 1'b1;
      busy         <= 1'b0;
    end else begin
      state     <= state_nx;
      cur       <= cur_nx;
      target    <= target_nx;
      depth     <= depth_nx;
      rate      <= rate_nx;
      rate_cnt  <= rate_cnt_nx;
      lfo       <= lfo_nx;
      dir       <= dir_nx;
      core_en   <= tick_act;
      cfg_ready <= (state_nx != ST_SLEW);
      busy      <= (state_nx == ST_SLEW);
      if (sample_tick)
        core_bypass <= bypass_req;
      if (tick_act)
        core_mod_val <= {{(16-SW){mod_nx[SW-1]}}, mod_nx};
    end
  end

endmodule

// File: tb/tb_delay_mod_ctrl.sv
// Testbench for delay_mod_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_delay_mod_ctrl;

  localparam int MAXD     = 255;
  localparam int RATE_MOD = 4096;
  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_SLEW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_tick, run, cfg_valid, cfg_ready, bypass_req;
  logic [7:0]        cfg_delay, cfg_depth;
  logic [11:0]       cfg_rate;
  logic              core_en, core_bypass, busy;
  logic [7:0]        core_base_delay;
  logic signed [15:0] core_mod_val;

  int errors = 0;
  int checks = 0;

  delay_mod_ctrl #(.ADDR_W(8), .RATE_W(12), .DEFAULT_DELAY(50)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_delay(cfg_delay),
    .cfg_depth(cfg_depth), .cfg_rate(cfg_rate), .bypass_req(bypass_req),
    .core_en(core_en), .core_bypass(core_bypass),
    .core_base_delay(core_base_delay), .core_mod_val(core_mod_val), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model, integers only
  int m_mode = MODE_IDLE, m_cur = 50, m_target = 50, m_depth = 0, m_rate = 0;
  int m_lfo = 0, m_dir = 1, m_rc = 0, m_mod = 0;
  bit m_en = 0, m_byp = 0, m_ready = 1, m_busy = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int  old_mode, old_cur, n_target;
    bit  acc;
    if (!rst_n) begin
      m_mode = MODE_IDLE; m_cur = 50; m_target = 50; m_depth = 0; m_rate = 0;
      m_lfo = 0; m_dir = 1; m_rc = 0; m_mod = 0;
      m_en = 0; m_byp = 0; m_ready = 1; m_busy = 0;
    end else begin
      acc      = cfg_valid && m_ready;
      old_mode = m_mode;
      old_cur  = m_cur;
      n_target = acc ? int'(cfg_delay) : m_target;
      m_en     = 0;
      if (sample_tick) m_byp = bypass_req;
      if (!run || old_mode == MODE_IDLE) begin
        m_cur = n_target; m_lfo = 0; m_dir = 1; m_rc = 0;
        m_mode = run ? MODE_RUN : MODE_IDLE;
      end else begin
        if (old_mode == MODE_RUN && acc && int'(cfg_delay) != old_cur)
          m_mode = MODE_SLEW;
        if (sample_tick) begin
          m_en = 1;
          if (old_mode == MODE_SLEW) begin
            m_cur += (m_target > m_cur) ? 1 : -1;
            if (m_cur == m_target) m_mode = MODE_RUN;
          end
          if (m_rc == m_rate) begin
            m_rc = 0;
            if (m_depth == 0) begin
              if (m_lfo > 0) m_lfo--; else if (m_lfo < 0) m_lfo++;
            end else begin
              if (m_lfo >= m_depth) m_dir = -1;
              else if (m_lfo <= -m_depth) m_dir = 1;
              m_lfo += m_dir;
              if (m_lfo >= m_depth) m_dir = -1;
              else if (m_lfo <= -m_depth) m_dir = 1;
            end
          end else begin
            m_rc = (m_rc + 1) % RATE_MOD;
          end
          m_mod = m_lfo;
          if (m_cur + m_lfo < 1) m_mod = 1 - m_cur;
          else if (m_cur + m_lfo > MAXD) m_mod = MAXD - m_cur;
        end
      end
      m_target = n_target;
      if (acc) begin m_depth = int'(cfg_depth); m_rate = int'(cfg_rate); end
      m_ready = (m_mode != MODE_SLEW);
      m_busy  = (m_mode == MODE_SLEW);
    end
  end

  // Ideal triangle for depth 3: value after s steps
  function automatic int tri_ref(int s);
    int p;
    p = s % 12;
    if (p <= 3) return p;
    if (p <= 9) return 6 - p;
    return p - 12;
  endfunction

  task automatic do_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Pass through idle, load a config, resume running with a fresh LFO
  task automatic configure(int d, int dp, int r);
    run = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_delay = 8'(d); cfg_depth = 8'(dp); cfg_rate = 12'(r);
    @(negedge clk);
    cfg_valid = 1'b0; run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", core_en); end
    checks++; if (core_bypass !== 1'b0) begin errors++; $display("FAIL reset_bypass got=%b exp=0", core_bypass); end
    checks++; if (core_base_delay !== 8'd50) begin errors++; $display("FAIL reset_delay got=%0d exp=50", core_base_delay); end
    checks++; if (core_mod_val !== 16'sd0) begin errors++; $display("FAIL reset_mod got=%0d exp=0", core_mod_val); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run_pulses();
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      repeat (9) @(negedge clk);
      checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL pulse_pre got=%b exp=0", core_en); end
      do_tick();
      checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL pulse_en got=%b exp=1", core_en); end
      checks++; if (core_base_delay !== 8'd50) begin errors++; $display("FAIL pulse_delay got=%0d exp=50", core_base_delay); end
      checks++; if (core_mod_val !== 16'sd0) begin errors++; $display("FAIL pulse_mod got=%0d exp=0", core_mod_val); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL pulse_ready got=%b exp=1", cfg_ready); end
      @(negedge clk);
      checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL pulse_width got=%b exp=0", core_en); end
    end
  endtask

  task automatic test_slew();
    cfg_valid = 1'b1; cfg_delay = 8'd54; cfg_depth = 8'd0; cfg_rate = 12'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL slew_busy got=%b exp=1", busy); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL slew_ready got=%b exp=0", cfg_ready); end
    checks++; if (core_base_delay !== 8'd50) begin errors++; $display("FAIL slew_hold got=%0d exp=50", core_base_delay); end
    for (int k = 1; k <= 4; k++) begin
      repeat (9) @(negedge clk);
      checks++; if (core_base_delay !== 8'(49 + k)) begin errors++; $display("FAIL slew_stable got=%0d exp=%0d", core_base_delay, 49 + k); end
      do_tick();
      checks++; if (core_base_delay !== 8'(50 + k)) begin errors++; $display("FAIL slew_step got=%0d exp=%0d", core_base_delay, 50 + k); end
      checks++; if (busy !== (k < 4)) begin errors++; $display("FAIL slew_busy_end got=%b exp=%b", busy, k < 4); end
      checks++; if (cfg_ready !== (k == 4)) begin errors++; $display("FAIL slew_ready_end got=%b exp=%b", cfg_ready, k == 4); end
    end
  endtask

  task automatic test_lfo();
    configure(50, 3, 1);
    for (int k = 1; k <= 26; k++) begin
      do_tick();
      checks++; if (int'(core_mod_val) != tri_ref(k / 2)) begin errors++; $display("FAIL lfo_tri tick=%0d got=%0d exp=%0d", k, core_mod_val, tri_ref(k / 2)); end
      checks++; if (core_base_delay !== 8'd50) begin errors++; $display("FAIL lfo_delay got=%0d exp=50", core_base_delay); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_clamp();
    int lo, hi;
    lo = 100;
    configure(2, 5, 0);
    for (int k = 1; k <= 30; k++) begin
      do_tick();
      if (int'(core_mod_val) < lo) lo = int'(core_mod_val);
      checks++; if (int'(core_mod_val) < -1) begin errors++; $display("FAIL clamp_low got=%0d exp>=-1", core_mod_val); end
      checks++; if (core_mod_val !== 16'(m_mod)) begin errors++; $display("FAIL clamp_low_model got=%0d exp=%0d", core_mod_val, m_mod); end
      @(negedge clk);
    end
    checks++; if (lo != -1) begin errors++; $display("FAIL clamp_low_reach got=%0d exp=-1", lo); end
    hi = -100;
    configure(254, 5, 0);
    for (int k = 1; k <= 30; k++) begin
      do_tick();
      if (int'(core_mod_val) > hi) hi = int'(core_mod_val);
      checks++; if (int'(core_mod_val) > 1) begin errors++; $display("FAIL clamp_high got=%0d exp<=1", core_mod_val); end
      checks++; if (core_mod_val !== 16'(m_mod)) begin errors++; $display("FAIL clamp_high_model got=%0d exp=%0d", core_mod_val, m_mod); end
      @(negedge clk);
    end
    checks++; if (hi != 1) begin errors++; $display("FAIL clamp_high_reach got=%0d exp=1", hi); end
  endtask

  task automatic test_bypass();
    repeat (2) @(negedge clk);
    bypass_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (core_bypass !== 1'b0) begin errors++; $display("FAIL bypass_early got=%b exp=0", core_bypass); end
    end
    do_tick();
    checks++; if (core_bypass !== 1'b1) begin errors++; $display("FAIL bypass_rise got=%b exp=1", core_bypass); end
    bypass_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (core_bypass !== 1'b1) begin errors++; $display("FAIL bypass_hold got=%b exp=1", core_bypass); end
    do_tick();
    checks++; if (core_bypass !== 1'b0) begin errors++; $display("FAIL bypass_fall got=%b exp=0", core_bypass); end
  endtask

  task automatic test_slew_abort();
    configure(60, 0, 0);
    cfg_valid = 1'b1; cfg_delay = 8'd80;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin do_tick(); @(negedge clk); end
    checks++; if (core_base_delay !== 8'd63) begin errors++; $display("FAIL abort_mid got=%0d exp=63", core_base_delay); end
    run = 1'b0; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL abort_en got=%b exp=0", core_en); end
    checks++; if (core_base_delay !== 8'd80) begin errors++; $display("FAIL abort_snap got=%0d exp=80", core_base_delay); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", cfg_ready); end
    do_tick();
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL idle_tick_en got=%b exp=0", core_en); end
  endtask

  task automatic test_reset_mid_slew();
    configure(60, 0, 0);
    bypass_req = 1'b1;
    cfg_valid = 1'b1; cfg_delay = 8'd80;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin do_tick(); @(negedge clk); end
    bypass_req = 1'b0;
    sample_tick = 1'b1;
    @(posedge clk);
    #2;
    sample_tick = 1'b0;
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL rst_pre_en got=%b exp=1", core_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL rst_async_en got=%b exp=0", core_en); end
    checks++; if (core_base_delay !== 8'd50) begin errors++; $display("FAIL rst_async_delay got=%0d exp=50", core_base_delay); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%b exp=1", cfg_ready); end
    checks++; if (core_bypass !== 1'b0) begin errors++; $display("FAIL rst_async_bypass got=%b exp=0", core_bypass); end
    checks++; if (core_mod_val !== 16'sd0) begin errors++; $display("FAIL rst_async_mod got=%0d exp=0", core_mod_val); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int dsel;
    for (int c = 0; c < 4000; c++) begin
      sample_tick = ($urandom_range(0, 3) == 0);
      if (run) begin
        if ($urandom_range(0, 149) == 0) run = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        run = 1'b1;
      end
      cfg_valid = ($urandom_range(0, 11) == 0);
      dsel = int'($urandom_range(0, 2));
      if (dsel == 0)      cfg_delay = 8'($urandom_range(0, 4));
      else if (dsel == 1) cfg_delay = 8'($urandom_range(248, 255));
      else                cfg_delay = 8'($urandom_range(40, 60));
      cfg_depth  = 8'($urandom_range(0, 7));
      cfg_rate   = 12'($urandom_range(0, 3));
      bypass_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (core_en !== m_en) begin errors++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", c, core_en, m_en); end
      checks++; if (core_bypass !== m_byp) begin errors++; $display("FAIL rnd_bypass cyc=%0d got=%b exp=%b", c, core_bypass, m_byp); end
      checks++; if (core_base_delay !== 8'(m_cur)) begin errors++; $display("FAIL rnd_delay cyc=%0d got=%0d exp=%0d", c, core_base_delay, m_cur); end
      checks++; if (core_mod_val !== 16'(m_mod)) begin errors++; $display("FAIL rnd_mod cyc=%0d got=%0d exp=%0d", c, core_mod_val, m_mod); end
      checks++; if (cfg_ready !== m_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, cfg_ready, m_ready); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, m_busy); end
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; sample_tick = 1'b0; cfg_valid = 1'b0;
    cfg_delay = 8'd0; cfg_depth = 8'd0; cfg_rate = 12'd0; bypass_req = 1'b0;
    test_reset();
    test_run_pulses();
    test_slew();
    test_lfo();
    test_clamp();
    test_bypass();
    test_slew_abort();
    test_reset_mid_slew();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
